// File: rtl/gshare_bht_if.sv
// Predict/update/status bundle between fetch, branch resolution and gshare_bht.
// master = front/back end driving requests, slave = the predictor.
interface gshare_bht_if #(
   parameter int unsigned PC_W   = 9,
   parameter int unsigned HIST_W = 4,
   parameter int unsigned STAT_W = 32
);
   logic              gshare_en;
   logic              pred_valid;
   logic [PC_W-1:0]   pred_pc;
   logic              pred_out_valid;
   logic              pred_taken;
   logic [HIST_W-1:0] pred_hist;
   logic              upd_valid;
   logic [PC_W-1:0]   upd_pc;
   logic [HIST_W-1:0] upd_hist;
   logic              upd_taken;
   logic              upd_mispredict;
   logic [HIST_W-1:0] ghr;
   logic [STAT_W-1:0] stat_total;
   logic [STAT_W-1:0] stat_miss;

   modport master (
      output gshare_en, pred_valid, pred_pc, upd_valid, upd_pc, upd_hist, upd_taken,
      input  pred_out_valid, pred_taken, pred_hist, upd_mispredict, ghr, stat_total, stat_miss
   );

   modport slave (
      input  gshare_en, pred_valid, pred_pc, upd_valid, upd_pc, upd_hist, upd_taken,
      output pred_out_valid, pred_taken, pred_hist, upd_mispredict, ghr, stat_total, stat_miss
   );
endinterface

// File: rtl/gshare_bht.sv
// Bimodal/gshare branch predictor: flop-based saturating counter table with
// independent predict and commit ports, committed global history and accuracy stats.
module gshare_bht #(
   parameter int unsigned PC_W   = 9,
   parameter int unsigned IDX_W  = 4,
   parameter int unsigned CTR_W  = 2,
   parameter int unsigned HIST_W = 4,
   parameter int unsigned STAT_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   gshare_bht_if.slave bus
);
   localparam int unsigned      DEPTH    = 1 << IDX_W;
   localparam logic [CTR_W-1:0] CTR_INIT = CTR_W'((64'd1 << (CTR_W - 1)) - 64'd1);
   localparam logic [CTR_W-1:0] CTR_MAX  = '1;

   logic [CTR_W-1:0]  ctr_q [DEPTH];
   logic [HIST_W-1:0] ghr_q;
   logic [HIST_W-1:0] pred_hist_q;
   logic              pred_vld_q;
   logic              pred_taken_q;
   logic              miss_q;
   logic [STAT_W-1:0] total_q;
   logic [STAT_W-1:0] miss_cnt_q;

   logic [IDX_W-1:0]  pred_idx;
   logic [IDX_W-1:0]  upd_idx;
   logic [CTR_W-1:0]  upd_old;
   logic [CTR_W-1:0]  upd_new;
   logic              upd_miss;

   function automatic logic [IDX_W-1:0] make_idx(input logic [PC_W-1:0]   pc,
                                                 input logic [HIST_W-1:0] hist,
                                                 input logic              gs);
      logic [IDX_W-1:0] hx;
      hx = gs ? IDX_W'(hist) : '0;
      return pc[IDX_W-1:0] ^ hx;
   endfunction

   always_comb begin
      pred_idx = make_idx(bus.pred_pc, ghr_q, bus.gshare_en);
      // Update index uses the returned history snapshot, not the live ghr.
      upd_idx  = make_idx(bus.upd_pc, bus.upd_hist, bus.gshare_en);
      upd_old  = ctr_q[upd_idx];
      upd_new  = upd_old;
      if (bus.upd_taken) begin
         if (upd_old != CTR_MAX) upd_new = upd_old + CTR_W'(1);
      end else begin
         if (upd_old != '0) upd_new = upd_old - CTR_W'(1);
      end
      upd_miss = upd_old[CTR_W-1] != bus.upd_taken;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) ctr_q[i] <= CTR_INIT;
         ghr_q        <= '0;
         pred_vld_q   <= 1'b0;
         pred_taken_q <= 1'b0;
         pred_hist_q  <= '0;
         miss_q       <= 1'b0;
         total_q      <= '0;
         miss_cnt_q   <= '0;
      end else begin
         pred_vld_q <= bus.pred_valid;
         if (bus.pred_valid) begin
            pred_taken_q <= ctr_q[pred_idx][CTR_W-1];
            pred_hist_q  <= ghr_q;
         end
         miss_q <= bus.upd_valid && upd_miss;
         if (bus.upd_valid) begin
            ctr_q[upd_idx] <= upd_new;
            // Truncating the concatenation drops the oldest bit; also covers HIST_W == 1.
            ghr_q <= HIST_W'({ghr_q, bus.upd_taken});
            if (total_q != '1) total_q <= total_q + STAT_W'(1);
            if (upd_miss && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + STAT_W'(1);
         end
      end
   end

   assign bus.pred_out_valid = pred_vld_q;
   assign bus.pred_taken     = pred_taken_q;
   assign bus.pred_hist      = pred_hist_q;
   assign bus.upd_mispredict = miss_q;
   assign bus.ghr            = ghr_q;
   assign bus.stat_total     = total_q;
   assign bus.stat_miss      = miss_cnt_q;
endmodule

// File: tb/tb_gshare_bht.sv
// Scoreboarded bench for gshare_bht: a reference model queues expected predictions
// and mispredict flags at drive time; a negedge monitor pops and compares them.
module tb_gshare_bht;
   localparam int unsigned PC_W   = 9;
   localparam int unsigned IDX_W  = 4;
   localparam int unsigned CTR_W  = 2;
   localparam int unsigned HIST_W = 4;
   localparam int unsigned STAT_W = 3;

   typedef struct { int due; logic taken; logic [HIST_W-1:0] hist; } pexp_t;
   typedef struct { int due; logic miss; } mexp_t;

   logic clk = 1'b0;
   logic reset;
   int   cyc_n  = 0;
   int   checks = 0;
   int   passed = 0;

   pexp_t pq[$];
   mexp_t mq[$];
   logic [CTR_W-1:0]  m_ctr [1 << IDX_W];
   logic [HIST_W-1:0] m_ghr;

   gshare_bht_if #(.PC_W(PC_W), .HIST_W(HIST_W), .STAT_W(STAT_W)) bus ();

   gshare_bht #(
      .PC_W(PC_W), .IDX_W(IDX_W), .CTR_W(CTR_W), .HIST_W(HIST_W), .STAT_W(STAT_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc_n++;

   function automatic logic [IDX_W-1:0] m_idx(input logic [PC_W-1:0] pc,
                                              input logic [HIST_W-1:0] h, input logic gs);
      logic [IDX_W-1:0] lo;
      lo = pc[IDX_W-1:0];
      return gs ? (lo ^ h) : lo;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < (1 << IDX_W); i++) m_ctr[i] = 2'b01;
      m_ghr = '0;
      pq.delete();
      mq.delete();
   endtask

   task automatic drive(input logic pv, input logic [PC_W-1:0] ppc, input logic uv,
                        input logic [PC_W-1:0] upc, input logic [HIST_W-1:0] uh,
                        input logic ut, input logic gs);
      logic [IDX_W-1:0] i;
      logic [CTR_W-1:0] old;
      pexp_t pe;
      mexp_t me;
      bus.gshare_en  = gs;
      bus.pred_valid = pv;
      bus.pred_pc    = ppc;
      bus.upd_valid  = uv;
      bus.upd_pc     = upc;
      bus.upd_hist   = uh;
      bus.upd_taken  = ut;
      if (pv) begin
         i        = m_idx(ppc, m_ghr, gs);
         pe.due   = cyc_n + 1;
         pe.taken = m_ctr[i][CTR_W-1];
         pe.hist  = m_ghr;
         pq.push_back(pe);
      end
      if (uv) begin
         i       = m_idx(upc, uh, gs);
         old     = m_ctr[i];
         me.due  = cyc_n + 1;
         me.miss = (old[CTR_W-1] != ut);
         mq.push_back(me);
         if (ut && old != 2'b11) m_ctr[i] = old + 2'b01;
         else if (!ut && old != 2'b00) m_ctr[i] = old - 2'b01;
         m_ghr = {m_ghr[HIST_W-2:0], ut};
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   always @(negedge clk) begin
      pexp_t pe;
      mexp_t me;
      logic  exp_m;
      if (!reset) begin
         if (pq.size() > 0 && pq[0].due == cyc_n) begin
            pe = pq.pop_front();
            checks++;
            if (bus.pred_out_valid !== 1'b1 || bus.pred_taken !== pe.taken || bus.pred_hist !== pe.hist)
               $display("FAIL pred cyc %0d: valid=%b taken=%b hist=%b, want valid=1 taken=%b hist=%b",
                        cyc_n, bus.pred_out_valid, bus.pred_taken, bus.pred_hist, pe.taken, pe.hist);
            else passed++;
         end else begin
            checks++;
            if (bus.pred_out_valid !== 1'b0)
               $display("FAIL pred_idle cyc %0d: valid=%b, want 0", cyc_n, bus.pred_out_valid);
            else passed++;
         end
         exp_m = 1'b0;
         if (mq.size() > 0 && mq[0].due == cyc_n) begin
            me    = mq.pop_front();
            exp_m = me.miss;
         end
         checks++;
         if (bus.upd_mispredict !== exp_m)
            $display("FAIL mispredict cyc %0d: got %b, want %b", cyc_n, bus.upd_mispredict, exp_m);
         else passed++;
      end
   end

   task automatic test_reset();
      checks++;
      if ({bus.pred_out_valid, bus.pred_taken, bus.pred_hist, bus.upd_mispredict} !== '0)
         $display("FAIL reset_pred: got %b%b%h%b, want all 0", bus.pred_out_valid,
                  bus.pred_taken, bus.pred_hist, bus.upd_mispredict);
      else passed++;
      checks++;
      if ({bus.ghr, bus.stat_total, bus.stat_miss} !== '0)
         $display("FAIL reset_state: ghr=%h total=%0d miss=%0d, want 0", bus.ghr,
                  bus.stat_total, bus.stat_miss);
      else passed++;
      reset = 1'b0;
      drive(1'b1, 9'd5, 1'b0, '0, '0, 1'b0, 1'b0);
      idle();
      checks++;
      if (bus.stat_total !== 3'd0) $display("FAIL first_total: got %0d, want 0", bus.stat_total);
      else passed++;
   endtask

   task automatic test_bimodal_sat();
      for (int k = 0; k < 3; k++) drive(1'b0, '0, 1'b1, 9'd5, '0, 1'b1, 1'b0);
      drive(1'b1, 9'd5, 1'b0, '0, '0, 1'b0, 1'b0);
      idle();
      checks++;
      if (bus.stat_total !== 3'd3 || bus.stat_miss !== 3'd1)
         $display("FAIL sat_stats: total=%0d miss=%0d, want 3/1", bus.stat_total, bus.stat_miss);
      else passed++;
   endtask

   task automatic test_bimodal_down();
      for (int k = 0; k < 4; k++) drive(1'b0, '0, 1'b1, 9'd5, '0, 1'b0, 1'b0);
      drive(1'b1, 9'd5, 1'b0, '0, '0, 1'b0, 1'b0);
      idle();
      checks++;
      if (bus.ghr !== 4'b0000) $display("FAIL down_ghr: got %b, want 0000", bus.ghr);
      else passed++;
      checks++;
      if (bus.stat_total !== 3'd7 || bus.stat_miss !== 3'd3)
         $display("FAIL down_stats: total=%0d miss=%0d, want 7/3", bus.stat_total, bus.stat_miss);
      else passed++;
   endtask

   task automatic test_gshare();
      drive(1'b0, '0, 1'b1, 9'd9, '0, 1'b1, 1'b1);
      drive(1'b0, '0, 1'b1, 9'd9, '0, 1'b1, 1'b1);
      drive(1'b0, '0, 1'b1, 9'd9, '0, 1'b0, 1'b1);
      checks++;
      if (bus.ghr !== 4'b0110) $display("FAIL gshare_ghr: got %b, want 0110", bus.ghr);
      else passed++;
      drive(1'b1, 9'd3, 1'b0, '0, '0, 1'b0, 1'b1);
      // train index 5 through its gshare alias, then reach it via a different pc/ghr pair
      drive(1'b0, '0, 1'b1, 9'd3, 4'b0110, 1'b1, 1'b1);
      drive(1'b0, '0, 1'b1, 9'd3, 4'b0110, 1'b1, 1'b1);
      drive(1'b1, 9'd14, 1'b0, '0, '0, 1'b0, 1'b1);
      drive(1'b1, 9'd14, 1'b0, '0, '0, 1'b0, 1'b0);
      idle();
      checks++;
      if (bus.ghr !== 4'b1011) $display("FAIL gshare_ghr2: got %b, want 1011", bus.ghr);
      else passed++;
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 9'd7, 1'b1, 9'd7, '0, 1'b1, 1'b0);
      drive(1'b1, 9'd7, 1'b0, '0, '0, 1'b0, 1'b0);
      idle();
   endtask

   task automatic test_stat_sat_reset();
      for (int k = 0; k < 9; k++) drive(1'b0, '0, 1'b1, 9'd7, '0, logic'(k % 2), 1'b0);
      idle();
      checks++;
      if (bus.stat_miss !== 3'd7 || bus.stat_total !== 3'd7)
         $display("FAIL stat_sat: miss=%0d total=%0d, want 7/7", bus.stat_miss, bus.stat_total);
      else passed++;
      drive(1'b1, 9'd5, 1'b1, 9'd7, '0, 1'b1, 1'b0);
      #1;
      reset = 1'b1;
      model_reset();
      #1;
      checks++;
      if ({bus.pred_out_valid, bus.pred_taken, bus.pred_hist, bus.upd_mispredict,
           bus.ghr, bus.stat_total, bus.stat_miss} !== '0)
         $display("FAIL async_reset: valid=%b taken=%b hist=%b misp=%b ghr=%b total=%0d miss=%0d, want 0",
                  bus.pred_out_valid, bus.pred_taken, bus.pred_hist, bus.upd_mispredict,
                  bus.ghr, bus.stat_total, bus.stat_miss);
      else passed++;
      bus.pred_valid = 1'b0;
      bus.upd_valid  = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b0;
      drive(1'b1, 9'd5, 1'b0, '0, '0, 1'b0, 1'b0);
      idle();
      idle();
   endtask

   initial begin
      reset = 1'b1;
      bus.gshare_en  = 1'b0;
      bus.pred_valid = 1'b0;
      bus.pred_pc    = '0;
      bus.upd_valid  = 1'b0;
      bus.upd_pc     = '0;
      bus.upd_hist   = '0;
      bus.upd_taken  = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      test_reset();
      test_bimodal_sat();
      test_bimodal_down();
      test_gshare();
      test_back_to_back();
      test_stat_sat_reset();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
